// File: rtl/wb_sequencer_if.sv
// Handshake bundle between main control, the source units and the write-back sequencer.
// The master side drives requests and source-valid flags; the slave side is the sequencer.
interface wb_sequencer_if;
  logic       start;
  logic [2:0] wb_class;
  logic [4:0] dest_reg;
  logic       mem_ready;
  logic       muldiv_busy;
  logic       shift_done;
  logic [2:0] mux_sel;
  logic [4:0] write_reg;
  logic       reg_write;
  logic       busy;
  logic       done;
  logic       timeout_err;

  modport master (
    output start, wb_class, dest_reg, mem_ready, muldiv_busy, shift_done,
    input  mux_sel, write_reg, reg_write, busy, done, timeout_err
  );

  modport slave (
    input  start, wb_class, dest_reg, mem_ready, muldiv_busy, shift_done,
    output mux_sel, write_reg, reg_write, busy, done, timeout_err
  );
endinterface

// File: rtl/wb_sequencer.sv
// Multicycle register-file write-back sequencer: waits for the selected source to become
// valid (bounded by a timeout), then issues a single-cycle write strobe.
//
// state    | meaning
// IDLE     | waiting for a start pulse
// WAIT_MEM | waiting for mem_ready
// LATCH    | one cycle for the MDR to load
// WAIT_MD  | waiting for mult/div to finish
// WAIT_SH  | waiting for shifter result
// WRITE    | reg_write strobe (dropped for $zero)
// FIN      | done pulse, return to IDLE
module wb_sequencer #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input logic           clock,
  input logic           reset_n,
  wb_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, WAIT_MEM, LATCH, WAIT_MD, WAIT_SH, WRITE, FIN
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       mux_q, mux_nxt;
  logic [4:0]       wreg_q, wreg_nxt;
  logic             tmo_nxt;
  logic             wait_ok;
  logic             reg_write_q, busy_q, done_q, tmo_q;

  always_comb begin
    wait_ok = 1'b0;
    case (state)
      WAIT_MEM: wait_ok = bus.mem_ready;
      WAIT_MD:  wait_ok = ~bus.muldiv_busy;
      WAIT_SH:  wait_ok = bus.shift_done;
      default:  wait_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mux_nxt   = mux_q;
    wreg_nxt  = wreg_q;
    tmo_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          mux_nxt  = bus.wb_class;
          wreg_nxt = bus.dest_reg;
          cnt_nxt  = '0;
          case (bus.wb_class)
            3'b010:  state_nxt = WAIT_MEM;
            3'b110:  state_nxt = WAIT_MD;
            3'b100:  state_nxt = WAIT_SH;
            default: state_nxt = WRITE;
          endcase
        end
      end
      WAIT_MEM, WAIT_MD, WAIT_SH: begin
        // A source that turns valid on the last allowed edge still wins over the abort.
        if (wait_ok) begin
          state_nxt = (state == WAIT_MEM) ? LATCH : WRITE;
        end else if (cnt == CNT_LAST) begin
          state_nxt = FIN;
          tmo_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      LATCH:   state_nxt = WRITE;
      WRITE:   state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      mux_q       <= 3'b000;
      wreg_q      <= 5'd0;
      reg_write_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      mux_q       <= mux_nxt;
      wreg_q      <= wreg_nxt;
      reg_write_q <= (state_nxt == WRITE) && (wreg_nxt != 5'd0);
      busy_q      <= (state_nxt != IDLE);
      done_q      <= (state_nxt == FIN);
      tmo_q       <= tmo_nxt;
    end
  end

  assign bus.mux_sel     = mux_q;
  assign bus.write_reg   = wreg_q;
  assign bus.reg_write   = reg_write_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.timeout_err = tmo_q;

endmodule

// File: doc/wb_sequencer.md
Name: wb_sequencer

Overview:
Multicycle write-back controller for the register-file write-data selector and register-file write port. It accepts one write-back request per instruction from the main control FSM and waits for the selected source to become valid: memory data register, HI/LO after mult/div, or shifter result. It then drives the 3-bit write-data select, destination register and a single-cycle RegWrite strobe. Wait states are bounded by a timeout so a stalled unit cannot hang the core.

Parameters:
TIMEOUT_CYCLES, 16, max cycles spent in any wait state before abort (range 2..255)
CNT_W, 8, width of the wait counter

Ports:
clock  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request pulse from main control
wb_class  input  3  source select: 000 ALUOut, 001 EPC, 010 MDR, 011 SLT result, 100 shifter, 101 PC (link), 110 HI/LO, 111 constant 227
dest_reg  input  5  destination register number
mem_ready  input  1  memory read data valid (MDR loads on the following edge)
muldiv_busy  input  1  mult/div unit busy; HI/LO invalid while high
shift_done  input  1  shifter result valid
mux_sel  output  3  write-data select, registered
write_reg  output  5  register-file write address, registered
reg_write  output  1  register-file write enable, registered, one-cycle pulse
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when a request completes, with or without a write
timeout_err  output  1  one-cycle pulse on a wait-state abort

Behaviour:
- Reset (asynchronous, any state): state IDLE; mux_sel=000, write_reg=0, reg_write=0, busy=0, done=0, timeout_err=0, counter=0. A request in flight is discarded and no write occurs.
- States: IDLE, WAIT_MEM, LATCH, WAIT_MD, WAIT_SH, WRITE, FIN.
- IDLE: if start=1 at edge N, register wb_class into mux_sel and dest_reg into write_reg, clear the counter, busy=1 from N. Next state: 010 -> WAIT_MEM; 110 -> WAIT_MD; 100 -> WAIT_SH; all others -> WRITE.
- start while busy=1 is ignored. No queueing; the main FSM must wait for done.
- WAIT_MEM: when mem_ready=1, go to LATCH. LATCH lasts exactly one cycle for the MDR load, then goes to WRITE.
- WAIT_MD: when muldiv_busy=0, go to WRITE. WAIT_SH: when shift_done=1, go to WRITE.
- Wait states: the condition is sampled on the edge; the counter increments every cycle the condition is false. When counter reaches TIMEOUT_CYCLES-1 with the condition still false, go to FIN with timeout_err=1 for one cycle and no write. A condition that is true on that same edge has priority over the timeout.
- WRITE: reg_write=1 for exactly one cycle, suppressed when write_reg=0 (the $zero write is dropped). Next state FIN.
- FIN: done=1 for one cycle, busy deasserts on the next edge, return to IDLE. A start in FIN is ignored; the earliest accepted start is in IDLE.
- mux_sel and write_reg hold their captured values from acceptance until the next accepted start, so data is stable around the write edge.
- Latency, start sampled at edge N:
  - Direct classes: reg_write in cycle N+1, done in N+2.
  - MDR with mem_ready already high: reg_write in N+3.
  - Minimum request-to-request spacing: 3 cycles.

Test Plan:
- Reset mid-WAIT_MEM (reset_n low for 1 cycle) -> all outputs 0 immediately, state IDLE, no reg_write afterwards even if mem_ready rises.
- start, wb_class=000, dest_reg=8 -> mux_sel=000 and write_reg=8 from N+1, reg_write=1 only in N+1, done=1 in N+2, busy low in N+3.
- wb_class=010, dest=9, mem_ready raised 3 cycles after start -> one LATCH cycle, then reg_write; mux_sel=010 throughout.
- wb_class=110, muldiv_busy held high 5 cycles then low -> reg_write one cycle after busy drops; second start during the wait is ignored (exactly one write).
- wb_class=100, shift_done never asserted, TIMEOUT_CYCLES=16 -> timeout_err pulse, then done pulse, reg_write never asserted.
- wb_class=111, dest=0 -> mux_sel=111, reg_write stays 0, done still pulses in N+2.
